// File: rtl/deque_cmd_ctrl_pkg.sv
// Shared types for the dual-deque command controller: command opcodes,
// controller FSM states and the bit layout of the STATUS response byte.
package deque_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_PUSH   = 2'b01,
    OP_POP    = 2'b10,
    OP_STATUS = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // Bit positions of the deque flags inside the STATUS byte; bits 7:4 are zero.
  localparam int unsigned STAT_D0_EMPTY_BIT = 0;
  localparam int unsigned STAT_D0_FULL_BIT  = 1;
  localparam int unsigned STAT_D1_EMPTY_BIT = 2;
  localparam int unsigned STAT_D1_FULL_BIT  = 3;

  function automatic logic [7:0] status_byte(input logic d0_empty, input logic d0_full,
                                             input logic d1_empty, input logic d1_full);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_D0_EMPTY_BIT] = d0_empty;
    b[STAT_D0_FULL_BIT]  = d0_full;
    b[STAT_D1_EMPTY_BIT] = d1_empty;
    b[STAT_D1_FULL_BIT]  = d1_full;
    return b;
  endfunction

endpackage

// File: rtl/deque_cmd_ctrl_if.sv
// Bus bundle between the host / dual deque and the command controller.
// master: host byte stream source, response sink and the deque itself.
// slave : the command controller.
interface deque_cmd_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       deque_select;
  logic       end_select;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic       d0_empty;
  logic       d0_full;
  logic       d1_empty;
  logic       d1_full;
  logic [7:0] data_out;
  logic       err;
  logic [3:0] err_count;

  modport master (
    output in_valid, in_data, rsp_ready,
    output d0_empty, d0_full, d1_empty, d1_full, data_out,
    input  in_ready, rsp_valid, rsp_data,
    input  deque_select, end_select, push, pop, data_in,
    input  err, err_count
  );

  modport slave (
    input  in_valid, in_data, rsp_ready,
    input  d0_empty, d0_full, d1_empty, d1_full, data_out,
    output in_ready, rsp_valid, rsp_data,
    output deque_select, end_select, push, pop, data_in,
    output err, err_count
  );
endinterface

// File: rtl/deque_cmd_ctrl.sv
// Command controller for a dual deque: decodes host command bytes into
// push/pop strobes or a status read and returns one response byte for POP
// and STATUS. Optional error tracking is enabled by DEQUE_CMD_CTRL_ERR_EN
// (push to a full deque / pop from an empty deque); otherwise err and
// err_count are tied to zero.
module deque_cmd_ctrl
  import deque_cmd_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  deque_cmd_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  cmd_op_e    op_q, op_d;
  logic       deque_sel_q, deque_sel_d;
  logic       end_sel_q, end_sel_d;
  logic [7:0] data_in_q, data_in_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  logic       in_ready_s;
  logic       rsp_valid_s;
  logic       push_s;
  logic       pop_s;
  logic       in_fire;
  logic       sel_empty;
  logic       sel_full;
  cmd_op_e    cmd_op;

  assign in_fire   = bus.in_valid && in_ready_s;
  assign cmd_op    = cmd_op_e'(bus.in_data[7:6]);
  assign sel_empty = deque_sel_q ? bus.d1_empty : bus.d0_empty;
  assign sel_full  = deque_sel_q ? bus.d1_full  : bus.d0_full;

  // State and latched command/payload/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      deque_sel_q <= 1'b0;
      end_sel_q   <= 1'b0;
      data_in_q   <= 8'h00;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      deque_sel_q <= deque_sel_d;
      end_sel_q   <= end_sel_d;
      data_in_q   <= data_in_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic; deque flags matter only in ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          case (cmd_op)
            OP_NOP:  state_d = ST_IDLE;
            OP_PUSH: state_d = ST_PAYLOAD;
            default: state_d = ST_ISSUE;
          endcase
        end
      end
      ST_PAYLOAD: if (in_fire) state_d = ST_ISSUE;
      ST_ISSUE: begin
        case (op_q)
          OP_POP:    state_d = sel_empty ? ST_RESP : ST_CAPTURE;
          OP_STATUS: state_d = ST_RESP;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Command, payload and response byte capture.
  always_comb begin
    op_d        = op_q;
    deque_sel_d = deque_sel_q;
    end_sel_d   = end_sel_q;
    data_in_d   = data_in_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          op_d        = cmd_op;
          deque_sel_d = bus.in_data[1];
          end_sel_d   = bus.in_data[0];
        end
      end
      ST_PAYLOAD: if (in_fire) data_in_d = bus.in_data;
      ST_ISSUE: begin
        if (op_q == OP_POP && sel_empty) rsp_data_d = 8'h00;
        if (op_q == OP_STATUS)
          rsp_data_d = status_byte(bus.d0_empty, bus.d0_full, bus.d1_empty, bus.d1_full);
      end
      ST_CAPTURE: rsp_data_d = bus.data_out;
      default: ;
    endcase
  end

  // Moore handshake outputs and the single-cycle deque strobes.
  always_comb begin
    in_ready_s  = (state_q == ST_IDLE) || (state_q == ST_PAYLOAD);
    rsp_valid_s = (state_q == ST_RESP);
    push_s      = (state_q == ST_ISSUE) && (op_q == OP_PUSH) && !sel_full;
    pop_s       = (state_q == ST_ISSUE) && (op_q == OP_POP) && !sel_empty;
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.rsp_valid    = rsp_valid_s;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.push         = push_s;
  assign bus.pop          = pop_s;
  assign bus.deque_select = deque_sel_q;
  assign bus.end_select   = end_sel_q;
  assign bus.data_in      = data_in_q;

`ifdef DEQUE_CMD_CTRL_ERR_EN
  logic       err_q, err_d;
  logic [3:0] err_count_q, err_count_d;
  logic       issue_err;

  assign issue_err = (state_q == ST_ISSUE) &&
                     (((op_q == OP_PUSH) && sel_full) || ((op_q == OP_POP) && sel_empty));

  // Sticky error flag and saturating error count, cleared only by reset.
  always_comb begin
    err_d       = err_q;
    err_count_d = err_count_q;
    if (issue_err) begin
      err_d = 1'b1;
      if (err_count_q != 4'hF) err_count_d = err_count_q + 4'd1;
    end
  end

  // Error tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      err_count_q <= 4'h0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
`else
  assign bus.err       = 1'b0;
  assign bus.err_count = 4'h0;
`endif

endmodule

// File: tb/tb_deque_cmd_ctrl.sv
// Directed self-checking bench for deque_cmd_ctrl. Error-count expectations
// follow DEQUE_CMD_CTRL_ERR_EN (zero when the macro is undefined).
module tb_deque_cmd_ctrl;

`ifdef DEQUE_CMD_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   push_cnt = 0;
  int   pop_cnt = 0;
  int   overlap_cnt = 0;

  deque_cmd_ctrl_if bus();

  deque_cmd_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count strobes as the deque would see them.
  always @(posedge clk) begin
    if (bus.push) push_cnt++;
    if (bus.pop) pop_cnt++;
    if (bus.push && bus.pop) overlap_cnt++;
  end

  // Offer one byte at a negedge, wait (bounded) for in_ready, transfer at posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!bus.in_ready) begin
      fails++;
      $display("[TB] FAIL send_timeout byte=%h in_ready=%b required 1", b, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.rsp_ready = 1'b0;
    bus.d0_empty = 1'b1; bus.d0_full = 1'b0; bus.d1_empty = 1'b1; bus.d1_full = 1'b0;
    bus.data_out = 8'h00;
    #2;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
    tests++; if ({bus.push, bus.pop} !== 2'b00) begin fails++; $display("[TB] FAIL rst_strobes got %b want 00", {bus.push, bus.pop}); end
    tests++; if ({bus.deque_select, bus.end_select} !== 2'b00) begin fails++; $display("[TB] FAIL rst_selects got %b want 00", {bus.deque_select, bus.end_select}); end
    tests++; if (bus.data_in !== 8'h00) begin fails++; $display("[TB] FAIL rst_data_in got %h want 00", bus.data_in); end
    tests++; if (bus.rsp_data !== 8'h00) begin fails++; $display("[TB] FAIL rst_rsp_data got %h want 00", bus.rsp_data); end
    tests++; if ({bus.err, bus.err_count} !== 5'h00) begin fails++; $display("[TB] FAIL rst_err got %b/%h want 0/0", bus.err, bus.err_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push();
    int p0;
    bus.d0_full = 1'b0;
    p0 = push_cnt;
    send_byte(8'h40);
    send_byte(8'hA5);
    tests++; if (bus.push !== 1'b1) begin fails++; $display("[TB] FAIL push_strobe got %b want 1", bus.push); end
    tests++; if (bus.data_in !== 8'hA5) begin fails++; $display("[TB] FAIL push_data_in got %h want a5", bus.data_in); end
    tests++; if ({bus.deque_select, bus.end_select} !== 2'b00) begin fails++; $display("[TB] FAIL push_selects got %b want 00", {bus.deque_select, bus.end_select}); end
    @(posedge clk); #1;
    tests++; if (bus.push !== 1'b0) begin fails++; $display("[TB] FAIL push_one_cycle got %b want 0", bus.push); end
    tests++; if (push_cnt - p0 !== 1) begin fails++; $display("[TB] FAIL push_count got %0d want 1", push_cnt - p0); end
  endtask

  task automatic test_pop();
    int q0;
    bus.d1_empty = 1'b0;
    bus.data_out = 8'h11;
    q0 = pop_cnt;
    send_byte(8'h83);
    tests++; if ({bus.pop, bus.push} !== 2'b10) begin fails++; $display("[TB] FAIL pop_strobe got pop/push %b want 10", {bus.pop, bus.push}); end
    tests++; if ({bus.deque_select, bus.end_select} !== 2'b11) begin fails++; $display("[TB] FAIL pop_selects got %b want 11", {bus.deque_select, bus.end_select}); end
    @(posedge clk); #1;
    bus.data_out = 8'h3C;
    tests++; if ({bus.pop, bus.rsp_valid} !== 2'b00) begin fails++; $display("[TB] FAIL pop_capture got pop/rsp_valid %b want 00", {bus.pop, bus.rsp_valid}); end
    @(posedge clk); #1;
    bus.data_out = 8'h77;
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL pop_latency got rsp_valid %b want 1 at T+3", bus.rsp_valid); end
    tests++; if (bus.rsp_data !== 8'h3C) begin fails++; $display("[TB] FAIL pop_rsp_data got %h want 3c", bus.rsp_data); end
    tests++; if (pop_cnt - q0 !== 1) begin fails++; $display("[TB] FAIL pop_count got %0d want 1", pop_cnt - q0); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests++; if ({bus.rsp_valid, bus.in_ready} !== 2'b01) begin fails++; $display("[TB] FAIL pop_release got rsp_valid/in_ready %b want 01", {bus.rsp_valid, bus.in_ready}); end
  endtask

  task automatic test_pop_empty();
    int q0;
    bus.d0_empty = 1'b1;
    bus.data_out = 8'h55;
    q0 = pop_cnt;
    send_byte(8'h80);
    tests++; if (bus.pop !== 1'b0) begin fails++; $display("[TB] FAIL empty_pop_strobe got %b want 0", bus.pop); end
    @(posedge clk); #1;
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL empty_latency got rsp_valid %b want 1 at T+2", bus.rsp_valid); end
    tests++; if (bus.rsp_data !== 8'h00) begin fails++; $display("[TB] FAIL empty_rsp_data got %h want 00", bus.rsp_data); end
    tests++; if (pop_cnt !== q0) begin fails++; $display("[TB] FAIL empty_pop_count got %0d want %0d", pop_cnt, q0); end
    tests++; if (bus.err !== ERR_EN) begin fails++; $display("[TB] FAIL empty_err got %b want %b", bus.err, ERR_EN); end
    tests++; if (bus.err_count !== (ERR_EN ? 4'd1 : 4'd0)) begin fails++; $display("[TB] FAIL empty_err_count got %0d want %0d", bus.err_count, ERR_EN ? 1 : 0); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_status();
    bus.d0_empty = 1'b1; bus.d0_full = 1'b0; bus.d1_empty = 1'b0; bus.d1_full = 1'b1;
    send_byte(8'hC0);
    @(posedge clk); #1;
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL status_latency got rsp_valid %b want 1 at T+2", bus.rsp_valid); end
    tests++; if (bus.rsp_data !== 8'h09) begin fails++; $display("[TB] FAIL status_data got %h want 09", bus.rsp_data); end
    bus.d0_empty = 1'b0; bus.d1_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({bus.rsp_valid, bus.in_ready, bus.rsp_data} !== {2'b10, 8'h09}) begin
        fails++;
        $display("[TB] FAIL status_hold cycle %0d got valid/ready/data %b/%b/%h want 1/0/09", i, bus.rsp_valid, bus.in_ready, bus.rsp_data);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL status_release got %b want 0", bus.rsp_valid); end
    bus.d0_full = 1'b1; bus.d1_empty = 1'b1;
    send_byte(8'hC3);
    @(posedge clk); #1;
    tests++; if (bus.rsp_data !== 8'h06) begin fails++; $display("[TB] FAIL status_data2 got %h want 06", bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_nop();
    int p0, q0;
    p0 = push_cnt; q0 = pop_cnt;
    send_byte(8'h3C);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL nop_in_ready got %b want 1", bus.in_ready); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({bus.rsp_valid, push_cnt - p0, pop_cnt - q0} !== {1'b0, 32'd0, 32'd0}) begin
      fails++; $display("[TB] FAIL nop_quiet got rsp_valid %b pushes %0d pops %0d want 0/0/0", bus.rsp_valid, push_cnt - p0, pop_cnt - q0);
    end
  endtask

  task automatic test_push_full();
    int p0;
    bus.d0_full = 1'b1; bus.d1_full = 1'b0;
    p0 = push_cnt;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h40);
      send_byte(8'hA5);
    end
    @(posedge clk); #1;
    tests++; if (push_cnt !== p0) begin fails++; $display("[TB] FAIL full_push_count got %0d want %0d", push_cnt, p0); end
    tests++; if (bus.err_count !== (ERR_EN ? 4'd15 : 4'd0)) begin fails++; $display("[TB] FAIL full_err_count got %0d want %0d", bus.err_count, ERR_EN ? 15 : 0); end
    tests++; if (bus.err !== ERR_EN) begin fails++; $display("[TB] FAIL full_err got %b want %b", bus.err, ERR_EN); end
    send_byte(8'h43);
    send_byte(8'h5A);
    tests++; if ({bus.push, bus.deque_select, bus.end_select, bus.data_in} !== {3'b111, 8'h5A}) begin
      fails++; $display("[TB] FAIL d1_push got push/dsel/esel/data %b/%b/%b/%h want 1/1/1/5a", bus.push, bus.deque_select, bus.end_select, bus.data_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int p0;
    bus.d0_full = 1'b0; bus.d0_empty = 1'b1; bus.d1_full = 1'b0; bus.d1_empty = 1'b1;
    p0 = push_cnt;
    send_byte(8'h41);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({bus.end_select, bus.deque_select, bus.data_in} !== 10'h000) begin
      fails++; $display("[TB] FAIL midrst_latches got esel/dsel/data %b/%b/%h want 0/0/00", bus.end_select, bus.deque_select, bus.data_in);
    end
    tests++; if ({bus.in_ready, bus.err, bus.err_count} !== 6'b100000) begin
      fails++; $display("[TB] FAIL midrst_state got in_ready/err/cnt %b/%b/%0d want 1/0/0", bus.in_ready, bus.err, bus.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (push_cnt !== p0) begin fails++; $display("[TB] FAIL midrst_no_push got %0d want %0d", push_cnt, p0); end
    send_byte(8'hC0);
    @(posedge clk); #1;
    tests++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 8'h05}) begin
      fails++; $display("[TB] FAIL midrst_status got valid/data %b/%h want 1/05", bus.rsp_valid, bus.rsp_data);
    end
    tests++; if (push_cnt !== p0) begin fails++; $display("[TB] FAIL midrst_payload_push got %0d want %0d", push_cnt, p0); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_pop_empty();
    test_status();
    test_nop();
    test_push_full();
    test_reset_mid();
    tests++;
    if (overlap_cnt !== 0) begin fails++; $display("[TB] FAIL push_pop_overlap got %0d want 0", overlap_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deque_cmd_ctrl.md
DEQUE_CMD_CTRL -- requirements
Module: deque_cmd_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-002 SHALL provide: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide: in_valid  input  1 / in_data  input  8 / in_ready  output  1  host byte stream, transfer when valid&ready.
REQ-004 SHALL provide: rsp_valid  output  1 / rsp_data  output  8 / rsp_ready  input  1  response byte, transfer when valid&ready.
REQ-005 SHALL provide: deque_select, end_select, push, pop  output  1 each / data_in  output  8  drive of the dual-deque port of the same names.
REQ-006 SHALL provide: d0_empty, d0_full, d1_empty, d1_full  input  1 each / data_out  input  8  dual-deque status and read data.
REQ-007 SHALL provide: err  output  1  sticky error flag / err_count  output  4  saturating error count.

Function
REQ-008 Command byte SHALL decode as bits[7:6] op (00 NOP, 01 PUSH, 10 POP, 11 STATUS), bit1 deque_select, bit0 end_select; bits[5:2] ignored.
REQ-009 FSM states SHALL be IDLE, PAYLOAD, ISSUE, CAPTURE, RESP; in_ready SHALL be 1 only in IDLE and PAYLOAD.
REQ-010 IDLE: accepted NOP -> IDLE; PUSH -> PAYLOAD; POP or STATUS -> ISSUE; selects latched from the command byte.
REQ-011 PAYLOAD: next accepted byte SHALL be latched to data_in, then -> ISSUE.
REQ-012 ISSUE/PUSH: if selected deque full, no strobe, -> IDLE; else push=1 for exactly this cycle, -> IDLE.
REQ-013 ISSUE/POP: if selected deque empty, rsp_data=8'h00, -> RESP; else pop=1 for exactly this cycle, -> CAPTURE.
REQ-014 CAPTURE: rsp_data SHALL latch data_out, -> RESP.
REQ-015 ISSUE/STATUS: rsp_data SHALL latch {4'b0, d1_full, d1_empty, d0_full, d0_empty}, -> RESP.
REQ-016 RESP: rsp_valid=1 and rsp_data stable until rsp_ready; on transfer -> IDLE.
REQ-017 Latency from accepted command at cycle T: POP rsp_valid at T+3 (T+2 if empty); STATUS at T+2; PUSH strobe at T'+1 after payload accepted at T'.
REQ-018 push and pop SHALL never be 1 together and SHALL never be 1 outside ISSUE.
REQ-019 deque_select, end_select, data_in SHALL be registered and stable from ISSUE entry through CAPTURE.
REQ-020 Full/empty SHALL be sampled in ISSUE only, using the flag pair of the latched deque_select.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, in_ready=1 after release, rsp_valid=0, push=0, pop=0, all selects 0, data_in=0, rsp_data=0, err=0, err_count=0.
REQ-022 Reset mid-transaction SHALL discard any latched command or payload; no strobe issued after release without a new command.

Configuration
REQ-023 With DEQUE_CMD_CTRL_ERR_EN defined, push to full or pop from empty SHALL set err and increment err_count, saturating at 15; both clear only on reset.
REQ-024 Without DEQUE_CMD_CTRL_ERR_EN, err and err_count SHALL be tied 0; all other behaviour identical.

Structure
REQ-025 Package deque_cmd_pkg SHALL hold the opcode enum, FSM state enum, and the STATUS byte layout constants.
REQ-026 Single module, no sub-module; the dual deque is instantiated beside it at the top level, not inside it.

Verification
REQ-027 Cmd 8'h40 (PUSH d0 end0), payload 8'hA5, d0_full=0 -> one-cycle push, data_in=8'hA5, deque_select=0, end_select=0.
REQ-028 Cmd 8'h83 (POP d1 end1), d1_empty=0, data_out=8'h3C in CAPTURE -> pop one cycle, rsp_valid at T+3, rsp_data=8'h3C.
REQ-029 Cmd 8'h80 with d0_empty=1 -> no pop, rsp_data=8'h00 at T+2; with macro err=1, err_count=1.
REQ-030 Cmd 8'hC0 with d0_empty=1, d1_full=1 -> rsp_data=8'h09; hold rsp_ready=0 five cycles -> rsp_valid and data stable, in_ready=0.
REQ-031 Seventeen PUSH commands to full d0 with macro -> no push strobes, err_count=15, err=1.
REQ-032 Assert rst_n low in PAYLOAD after cmd 8'h41 -> no push strobe ever; next byte 8'hC0 decodes as STATUS.
